// File: rtl/trigger_window_cache.sv
// Trigger-surround cache: keeps PRE samples before and POST samples from a threshold
// crossing, timestamps the trigger, then streams the window oldest-first on req/rdy.
module trigger_window_cache #(
  parameter int DATA_W = 8,
  parameter int PRE    = 16,
  parameter int POST   = 16,
  parameter int TS_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] thresh,
  input  logic [1:0]        trig_mode,
  input  logic              sbf,
  input  logic              req,
  output logic              trd,
  output logic              cd,
  output logic [TS_W-1:0]   trigtm,
  output logic              rdy,
  output logic [DATA_W-1:0] dat,
  output logic              sd,
  output logic [2:0]        current_state
);

  localparam int DEPTH  = PRE + POST;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  PRE_LAST   = CNT_W'(PRE - 1);
  localparam logic [CNT_W-1:0]  POST_LAST  = CNT_W'(POST - 1);
  localparam logic [CNT_W-1:0]  DEPTH_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4,
    S_SEND = 3'd5
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [TS_W-1:0]   ctr;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              rise;
  logic              fall;
  logic              hit;
  logic              wr_en;

  assign current_state = state;

  always_comb begin
    rise  = prev_valid && (prev < thresh) && (adc_data >= thresh);
    fall  = prev_valid && (prev >= thresh) && (adc_data < thresh);
    hit   = 1'b0;
    case (trig_mode)
      2'b00:   hit = rise;
      2'b01:   hit = fall;
      2'b10:   hit = rise | fall;
      default: hit = (adc_data >= thresh);
    endcase
    wr_en = adc_valid && ((state == S_ARM) || (state == S_WAIT) || (state == S_POST));
  end

  // Sample storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= adc_data;
  end

  // cnt is reused: PRE fill count in ARM, post-trigger samples in POST, pops in SEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      ctr        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      trd        <= 1'b0;
      cd         <= 1'b0;
      trigtm     <= '0;
      rdy        <= 1'b0;
      dat        <= '0;
      sd         <= 1'b0;
    end else begin
      ctr <= ctr + 1'b1;
      sd  <= 1'b0;
      if (wr_en) begin
        wr_ptr     <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
        prev       <= adc_data;
        prev_valid <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_ARM;
            wr_ptr     <= '0;
            cnt        <= '0;
            prev_valid <= 1'b0;
            trd        <= 1'b0;
            cd         <= 1'b0;
          end
        end
        S_ARM: begin
          if (adc_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == PRE_LAST) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (adc_valid && hit) begin
            trigtm <= ctr;
            trd    <= 1'b1;
            cnt    <= CNT_W'(1);
            if (POST == 1) begin
              state <= S_DONE;
              cd    <= 1'b1;
            end else begin
              state <= S_POST;
            end
          end
        end
        S_POST: begin
          if (adc_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == POST_LAST) begin
              state <= S_DONE;
              cd    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (sbf) begin
            state  <= S_SEND;
            rd_ptr <= wr_ptr;
            cnt    <= '0;
          end
        end
        S_SEND: begin
          // Alternate load and pop cycles, giving one word every two clocks.
          if (!rdy) begin
            dat <= mem[rd_ptr];
            rdy <= 1'b1;
          end else if (req) begin
            rdy    <= 1'b0;
            rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
            cnt    <= cnt + 1'b1;
            if (cnt == DEPTH_LAST) begin
              sd    <= 1'b1;
              trd   <= 1'b0;
              cd    <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_window_cache.sv
// Bench for trigger_window_cache: a behavioural capture model pushes the expected window
// into a scoreboard queue as samples are driven; readout pops and compares it.
module tb_trigger_window_cache;

  localparam int DATA_W = 8;
  localparam int PRE    = 4;
  localparam int POST   = 4;
  localparam int TS_W   = 32;
  localparam int DEPTH  = PRE + POST;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic [DATA_W-1:0] thresh;
  logic [1:0]        trig_mode;
  logic              sbf;
  logic              req;
  logic              trd;
  logic              cd;
  logic [TS_W-1:0]   trigtm;
  logic              rdy;
  logic [DATA_W-1:0] dat;
  logic              sd;
  logic [2:0]        current_state;

  int checks = 0;
  int passed = 0;

  logic [TS_W-1:0]   model_ctr;
  logic [DATA_W-1:0] stim_q[$];
  logic [DATA_W-1:0] hist[$];
  logic [DATA_W-1:0] exp_q[$];
  int                m_phase = 0;
  int                m_cnt;
  logic [DATA_W-1:0] m_prev;
  logic              m_trd = 1'b0;
  logic [TS_W-1:0]   exp_trigtm = '0;

  trigger_window_cache #(
    .DATA_W(DATA_W), .PRE(PRE), .POST(POST), .TS_W(TS_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .adc_data(adc_data), .adc_valid(adc_valid),
    .thresh(thresh), .trig_mode(trig_mode), .sbf(sbf), .req(req), .trd(trd), .cd(cd),
    .trigtm(trigtm), .rdy(rdy), .dat(dat), .sd(sd), .current_state(current_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) model_ctr <= '0;
    else       model_ctr <= model_ctr + 1'b1;
  end

  function automatic bit trig_hit(input logic [1:0] m, input logic [DATA_W-1:0] p,
                                  input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] th);
    bit r, f;
    r = (p < th) && (c >= th);
    f = (p >= th) && (c < th);
    case (m)
      2'b00:   return r;
      2'b01:   return f;
      2'b10:   return r || f;
      default: return c >= th;
    endcase
  endfunction

  // Advances the capture model by one accepted sample; called in the cycle it is driven.
  task automatic model_sample(input logic [DATA_W-1:0] s);
    int old_phase;
    old_phase = m_phase;
    case (m_phase)
      1: begin
        hist.push_back(s);
        m_cnt++;
        if (m_cnt == PRE) m_phase = 2;
      end
      2: begin
        hist.push_back(s);
        if (trig_hit(trig_mode, m_prev, s, thresh)) begin
          exp_trigtm = model_ctr;
          m_trd      = 1'b1;
          m_cnt      = 1;
          m_phase    = (m_cnt == POST) ? 4 : 3;
        end
      end
      3: begin
        hist.push_back(s);
        m_cnt++;
        if (m_cnt == POST) m_phase = 4;
      end
      default: ;
    endcase
    if (old_phase >= 1 && old_phase <= 3) m_prev = s;
    while (hist.size() > DEPTH) void'(hist.pop_front());
    if (old_phase != 4 && m_phase == 4) begin
      foreach (hist[i]) exp_q.push_back(hist[i]);
    end
  endtask

  task automatic run_capture(input logic [1:0] mode, input int gap, input bit start_in_wait);
    logic [2:0] ph;
    trig_mode = mode;
    @(negedge clk);
    start   = 1'b1;
    m_phase = 1;
    m_cnt   = 0;
    m_trd   = 1'b0;
    hist.delete();
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (current_state !== 3'd1) $display("[TB] FAIL arm_entry: got %0d expected 1", current_state);
    else passed++;
    foreach (stim_q[i]) begin
      adc_valid = 1'b1;
      adc_data  = stim_q[i];
      model_sample(stim_q[i]);
      for (int g = 0; g <= gap; g++) begin
        @(negedge clk);
        ph = m_phase[2:0];
        checks++;
        if (current_state !== ph || trd !== m_trd || cd !== (m_phase == 4))
          $display("[TB] FAIL capture_step %0d: got state=%0d trd=%0b cd=%0b expected state=%0d trd=%0b cd=%0b",
                   i, current_state, trd, cd, ph, m_trd, (m_phase == 4));
        else passed++;
        adc_valid = 1'b0;
        adc_data  = 8'($urandom);
        start     = start_in_wait && (g < gap) && (m_phase == 2);
      end
      start = 1'b0;
    end
    adc_valid = 1'b0;
    checks++;
    if (current_state !== 3'd4 || cd !== 1'b1 || trd !== 1'b1 || trigtm !== exp_trigtm)
      $display("[TB] FAIL capture_done: got state=%0d cd=%0b trd=%0b trigtm=%0d expected state=4 cd=1 trd=1 trigtm=%0d",
               current_state, cd, trd, trigtm, exp_trigtm);
    else passed++;
  endtask

  // hold=1 keeps req high throughout; hold=0 makes every word wait one extra cycle.
  task automatic read_window(input bit hold);
    int  words;
    int  seen;
    bit  done;
    words = 0;
    seen  = 0;
    done  = 1'b0;
    @(negedge clk);
    sbf = 1'b1;
    req = hold;
    @(negedge clk);
    sbf = 1'b0;
    checks++;
    if (current_state !== 3'd5 || rdy !== 1'b0)
      $display("[TB] FAIL send_entry: got state=%0d rdy=%0b expected state=5 rdy=0", current_state, rdy);
    else passed++;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (sd) begin
        done = 1'b1;
        checks++;
        if (words != DEPTH || exp_q.size() != 0 || current_state !== 3'd0 || rdy !== 1'b0 ||
            trd !== 1'b0 || cd !== 1'b0)
          $display("[TB] FAIL send_done: got words=%0d left=%0d state=%0d rdy=%0b trd=%0b cd=%0b expected %0d 0 0 0 0 0",
                   words, exp_q.size(), current_state, rdy, trd, cd, DEPTH);
        else passed++;
      end
      if (rdy) begin
        seen++;
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL readout_extra: got dat=%0d expected no word", dat);
        else if (dat !== exp_q[0])
          $display("[TB] FAIL readout_word %0d: got %0d expected %0d", words, dat, exp_q[0]);
        else passed++;
        if (hold || seen > 1) begin
          req = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          words++;
          seen = 0;
        end else begin
          req = 1'b0;
        end
      end else begin
        req = hold;
      end
    end
    req = 1'b0;
    checks++;
    if (!done) $display("[TB] FAIL send_timeout: got words=%0d expected sd within bound", words);
    else passed++;
    @(negedge clk);
    checks++;
    if (sd !== 1'b0) $display("[TB] FAIL sd_pulse_width: got sd=%0b expected 0", sd);
    else passed++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (current_state !== 3'd0 || trd !== 1'b0 || cd !== 1'b0 || rdy !== 1'b0 || sd !== 1'b0 ||
        dat !== '0 || trigtm !== '0)
      $display("[TB] FAIL reset_values: got state=%0d trd=%0b cd=%0b rdy=%0b sd=%0b dat=%0d trigtm=%0d expected all 0",
               current_state, trd, cd, rdy, sd, dat, trigtm);
    else passed++;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (current_state !== 3'd0) $display("[TB] FAIL start_in_reset: got state=%0d expected 0", current_state);
    else passed++;
  endtask

  task automatic test_rising;
    stim_q.delete();
    for (int v = 0; v <= 150; v += 10) stim_q.push_back(8'(v));
    run_capture(2'b00, 0, 1'b0);
    read_window(1'b0);
  endtask

  task automatic test_falling;
    stim_q = '{8'd200, 8'd50, 8'd200, 8'd50, 8'd200, 8'd200, 8'd40, 8'd30, 8'd20, 8'd10};
    run_capture(2'b01, 0, 1'b0);
    read_window(1'b1);
  endtask

  task automatic test_gaps;
    stim_q.delete();
    for (int v = 0; v <= 150; v += 10) stim_q.push_back(8'(v));
    run_capture(2'b00, 2, 1'b1);
  endtask

  task automatic test_req_held;
    read_window(1'b1);
  endtask

  task automatic test_reset_mid_send;
    int words;
    stim_q = '{8'd150, 8'd150, 8'd10, 8'd20, 8'd30, 8'd100, 8'd7, 8'd8, 8'd9};
    run_capture(2'b11, 0, 1'b0);
    words = 0;
    @(negedge clk);
    sbf = 1'b1;
    req = 1'b1;
    @(negedge clk);
    sbf = 1'b0;
    for (int cyc = 0; cyc < 100 && words < 3; cyc++) begin
      @(negedge clk);
      if (rdy) begin
        checks++;
        if (exp_q.size() == 0 || dat !== exp_q[0])
          $display("[TB] FAIL partial_word %0d: got %0d expected %0d", words, dat,
                   (exp_q.size() == 0) ? 8'd0 : exp_q[0]);
        else passed++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        words++;
      end
    end
    checks++;
    if (words != 3) $display("[TB] FAIL partial_timeout: got words=%0d expected 3", words);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    req   = 1'b0;
    @(negedge clk);
    checks++;
    if (current_state !== 3'd0 || rdy !== 1'b0 || sd !== 1'b0 || trd !== 1'b0 || cd !== 1'b0 ||
        trigtm !== '0 || dat !== '0)
      $display("[TB] FAIL reset_mid_send: got state=%0d rdy=%0b sd=%0b trd=%0b cd=%0b trigtm=%0d dat=%0d expected all 0",
               current_state, rdy, sd, trd, cd, trigtm, dat);
    else passed++;
    reset = 1'b0;
    exp_q.delete();
    m_phase = 0;
    m_trd   = 1'b0;
    stim_q = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd150, 8'd90, 8'd80, 8'd70, 8'd60};
    run_capture(2'b10, 0, 1'b0);
    read_window(1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    adc_data  = '0;
    adc_valid = 1'b0;
    thresh    = 8'd100;
    trig_mode = 2'b00;
    sbf       = 1'b0;
    req       = 1'b0;
    test_reset();
    test_rising();
    test_falling();
    test_gaps();
    test_req_held();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
